// File: rtl/issue_scoreboard_ctrl.sv
// issue_scoreboard_ctrl: decode-stage issue/stall/flush control.
// Countdown scoreboard blocks RAW/WAW; drains writes before halt.
module issue_scoreboard_ctrl #(
  parameter int ALU_LAT      = 2,
  parameter int LOAD_LAT     = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [4:0]  i_rs1_addr,
  input  logic        i_rs1_used,
  input  logic [4:0]  i_rs2_addr,
  input  logic        i_rs2_used,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wen,
  input  logic        i_is_load,
  input  logic        i_halt,
  input  logic        i_redirect,
  output logic        o_issue,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_halted,
  output logic [31:0] o_busy_mask,
  output logic [15:0] o_stall_cycles
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LD_CNT = CNT_W'(LOAD_LAT);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [FC_W-1:0]  fcnt_q;
  logic [FC_W-1:0]  fcnt_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [31:0]      busy;
  logic             hazard;
  logic             idle;
  logic             track;
  logic [15:0]      stall_q;

  // busy bit per register; x0 is never tracked
  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign hazard = i_valid
                & ((i_rs1_used & busy[i_rs1_addr])
                 | (i_rs2_used & busy[i_rs2_addr])
                 | (i_rd_wen & busy[i_rd_addr]));

  assign idle  = (busy == '0);
  assign track = o_issue & i_rd_wen & (i_rd_addr != 5'd0);

  // next state and issue/stall decisions
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    o_issue = 1'b0;
    o_stall = 1'b0;
    unique case (state_q)
      S_RUN: begin
        o_issue = i_valid & ~hazard & ~i_redirect;
        o_stall = hazard & ~i_redirect;
        if (i_redirect) begin
          state_d = S_FLUSH;
          fcnt_d  = FC_LAST;
        end else if (o_issue & i_halt) begin
          state_d = S_DRAIN;
        end
      end
      S_FLUSH: begin
        if (i_redirect) begin
          fcnt_d = FC_LAST;
        end else if (fcnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      S_DRAIN: begin
        o_stall = i_valid;
        if (idle) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
    endcase
    if (i_rst) begin
      o_issue = 1'b0;
      o_stall = 1'b0;
    end
  end

  // state register and flush countdown
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // scoreboard: tracked issue reloads, otherwise count down to 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (track && (i_rd_addr == 5'(r))) begin
          cnt_q[r] <= i_is_load ? LD_CNT : ALU_CNT;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q <= '0;
    end else if (o_stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_flush        = (state_q == S_FLUSH);
  assign o_halted       = (state_q == S_HALTED);
  assign o_busy_mask    = busy;
  assign o_stall_cycles = stall_q;

endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
- Issue controller for the decode stage: decides each cycle whether the instruction in decode may be issued, must stall, or must be squashed.
- Tracks in-flight register-file writes with a per-register countdown scoreboard and blocks RAW/WAW hazards (no forwarding).
- Sequences pipeline flush after a PC redirect, and drains all in-flight writes before asserting halt.

Parameters:
- ALU_LAT, 2, cycles from issue until a non-load result is written back (1..2^CNT_W-1)
- LOAD_LAT, 3, cycles from issue until a load result is written back (1..2^CNT_W-1)
- FLUSH_CYCLES, 2, number of cycles o_flush stays asserted per redirect (>=1)
- CNT_W, 3, width of each scoreboard counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  decode holds a valid instruction
- i_rs1_addr  in  5  source register 1
- i_rs1_used  in  1  instruction reads rs1
- i_rs2_addr  in  5  source register 2
- i_rs2_used  in  1  instruction reads rs2
- i_rd_addr  in  5  destination register
- i_rd_wen  in  1  instruction writes rd
- i_is_load  in  1  instruction is a load (uses LOAD_LAT)
- i_halt  in  1  instruction is the halt instruction
- i_redirect  in  1  execute resolved a taken branch/jump this cycle
- o_issue  out  1  instruction accepted this cycle (combinational)
- o_stall  out  1  hold fetch/decode this cycle (combinational)
- o_flush  out  1  squash younger pipeline contents (registered)
- o_halted  out  1  core halted, sticky until reset (registered)
- o_busy_mask  out  32  bit r = scoreboard counter r nonzero; bit 0 always 0
- o_stall_cycles  out  16  saturating count of cycles with o_stall=1

Behaviour:
- Clock, reset: single clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset state:
  - state=RUN, all counters 0.
  - o_flush=0, o_halted=0, o_busy_mask=0, o_stall_cycles=0.
  - o_issue and o_stall are forced 0 in any cycle where i_rst=1.
- Hazard (combinational) = i_valid AND any of:
  - i_rs1_used & rs1≠0 & cnt[rs1]≠0
  - i_rs2_used & rs2≠0 & cnt[rs2]≠0
  - i_rd_wen & rd≠0 & cnt[rd]≠0 (WAW)
- Register x0 never creates a hazard and is never tracked.
- Scoreboard, every cycle:
  - Each nonzero counter decrements by 1.
  - On o_issue with i_rd_wen & rd≠0: cnt[rd] loads LOAD_LAT if i_is_load, else ALU_LAT. The load overrides the decrement.
- States:
  - RUN:
    - o_issue = i_valid & ~hazard & ~i_redirect
    - o_stall = i_valid & hazard & ~i_redirect
    - i_redirect -> FLUSH. Redirect wins over a simultaneous issue or halt; that instruction does not issue.
    - o_issue & i_halt -> DRAIN.
  - FLUSH:
    - o_flush=1 for exactly FLUSH_CYCLES cycles, starting the cycle after i_redirect is sampled.
    - o_issue=0, o_stall=0. Decode contents are discarded and do not touch the scoreboard.
    - i_redirect during FLUSH restarts the full FLUSH_CYCLES count.
    - After the last flush cycle -> RUN.
  - DRAIN:
    - o_issue=0, o_stall=i_valid; i_redirect ignored.
    - When all counters are 0 -> HALTED; o_halted=1 from the next cycle.
  - HALTED: o_issue=0, o_stall=0, o_flush=0, o_halted=1. All inputs are ignored until reset.
- o_stall_cycles increments on every cycle with o_stall=1 and holds at 0xFFFF.
- Reset asserted mid-FLUSH or mid-DRAIN returns to the reset state at the next edge.

Test Plan:
- Reset: hold i_rst 3 cycles with random inputs -> o_issue=o_stall=o_flush=o_halted=0, o_busy_mask=0, o_stall_cycles=0.
- Load-use: issue load x5 at cycle 0, then add x6←x5 valid from cycle 1 -> o_busy_mask[5]=1 cycles 1-3, o_stall=1 cycles 1-3, o_issue=1 cycle 4, o_stall_cycles=3.
- x0 and unused sources: load x0 at cycle 0, then an instr reading x0, plus an instr with i_rs1_used=0 naming a busy reg -> both issue with no stall; o_busy_mask[0]=0.
- Redirect: i_redirect=1 at cycle 10 with valid non-hazard instr -> o_issue=0 at cycle 10, o_flush=1 cycles 11-12, issue resumes cycle 13. Second redirect at cycle 11 -> o_flush stays high through cycle 13.
- Halt drain: load x7 issued cycle 0, halt issued cycle 1 -> DRAIN cycles 2-4, o_halted=1 from cycle 5 and sticky. A later i_redirect produces no o_flush.
- Saturation and WAW: hold a permanent hazard >65535 cycles -> o_stall_cycles=0xFFFF. Write to a busy rd -> stalls until its counter reaches 0.
